// File: rtl/alu_sequencer.sv
// Instruction sequencer driving ALU controls, MUL/DIV start/done handshake and output-register strobes.
// Optional WAIT-state abort counter enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_instr_valid,
    output logic        o_instr_ready,
    input  logic [7:0]  i_instr,
    output logic [2:0]  o_alu_op_select,
    output logic        o_alu_sub,
    output logic        o_alu_start,
    input  logic        i_alu_done,
    output logic        o_out_we,
    output logic        o_out_re,
    output logic [4:0]  o_out_index,
    output logic        o_retire,
    output logic [15:0] o_retired_count,
    output logic        o_illegal,
    output logic        o_timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WAIT
    } seqStateT;

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpSub  = 4'h1;
    localparam logic [3:0] OpMul  = 4'h4;
    localparam logic [3:0] OpDiv  = 4'h5;
    localparam logic [3:0] OpOutW = 4'h6;
    localparam logic [3:0] OpOutR = 4'h7;

    seqStateT    r_state;
    seqStateT    w_stateNext;
    logic [7:0]  r_ir;
    logic [15:0] r_retiredCount;
    logic        w_retire;
    logic        w_expire;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_ir           <= 8'h00;
            r_retiredCount <= 16'h0000;
        end else begin
            r_state <= w_stateNext;
            if (r_state == IDLE && i_instr_valid) begin
                r_ir <= i_instr;
            end
            if (w_retire) begin
                r_retiredCount <= r_retiredCount + 16'd1;
            end
        end
    end

    // Controls depend on state and ir; only WAIT completion looks at alu_done.
    always_comb begin
        w_stateNext     = r_state;
        o_instr_ready   = 1'b0;
        o_alu_op_select = 3'b000;
        o_alu_sub       = 1'b0;
        o_alu_start     = 1'b0;
        o_out_we        = 1'b0;
        o_out_re        = 1'b0;
        o_illegal       = 1'b0;
        w_retire        = 1'b0;
        case (r_state)
            IDLE: begin
                o_instr_ready = 1'b1;
                if (i_instr_valid) begin
                    w_stateNext = EXEC;
                end
            end
            EXEC: begin
                w_stateNext = IDLE;
                case (r_ir[7:4])
                    OpAdd: begin
                        w_retire = 1'b1;
                    end
                    OpSub: begin
                        o_alu_op_select = 3'b001;
                        o_alu_sub       = 1'b1;
                        w_retire        = 1'b1;
                    end
                    OpMul, OpDiv: begin
                        o_alu_op_select = {2'b10, r_ir[4]};
                        o_alu_start     = 1'b1;
                        w_stateNext     = WAIT;
                    end
                    OpOutW: begin
                        o_out_we = 1'b1;
                        w_retire = 1'b1;
                    end
                    OpOutR: begin
                        o_out_re = 1'b1;
                        w_retire = 1'b1;
                    end
                    default: begin
                        o_illegal = 1'b1;
                    end
                endcase
            end
            WAIT: begin
                o_alu_op_select = {2'b10, r_ir[4]};
                if (i_alu_done) begin
                    w_retire    = 1'b1;
                    w_stateNext = IDLE;
                end else if (w_expire) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT);

    logic [CntW-1:0] r_waitCnt;
    logic            r_timeoutErr;

    assign w_expire = (r_waitCnt == CntW'(TIMEOUT - 1));

    // Counter restarts every EXEC so each WAIT visit gets the full budget.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_waitCnt    <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            if (r_state == EXEC) begin
                r_waitCnt <= '0;
            end else if (r_state == WAIT) begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end
            if (r_state == WAIT && !i_alu_done && w_expire) begin
                r_timeoutErr <= 1'b1;
            end
        end
    end

    assign o_timeout_err = r_timeoutErr;
`else
    logic w_unusedTimeout;

    assign w_unusedTimeout = (TIMEOUT >= 2);
    assign w_expire        = 1'b0;
    assign o_timeout_err   = 1'b0;
`endif

    assign o_out_index     = {1'b0, r_ir[3:0]};
    assign o_retire        = w_retire;
    assign o_retired_count = r_retiredCount;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; expected values are hand-computed per vector.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
module tb_alu_sequencer;

    logic        clk;
    logic        rstN;
    logic        instrValid;
    logic        instrReady;
    logic [7:0]  instr;
    logic [2:0]  aluOpSelect;
    logic        aluSub;
    logic        aluStart;
    logic        aluDone;
    logic        outWe;
    logic        outRe;
    logic [4:0]  outIndex;
    logic        retire;
    logic [15:0] retiredCount;
    logic        illegal;
    logic        timeoutErr;

    int numCompared   = 0;
    int numMismatched = 0;
    int expCount      = 0;

    alu_sequencer #(.TIMEOUT(8)) dut (
        .i_clk           (clk),
        .i_rst_n         (rstN),
        .i_instr_valid   (instrValid),
        .o_instr_ready   (instrReady),
        .i_instr         (instr),
        .o_alu_op_select (aluOpSelect),
        .o_alu_sub       (aluSub),
        .o_alu_start     (aluStart),
        .i_alu_done      (aluDone),
        .o_out_we        (outWe),
        .o_out_re        (outRe),
        .o_out_index     (outIndex),
        .o_retire        (retire),
        .o_retired_count (retiredCount),
        .o_illegal       (illegal),
        .o_timeout_err   (timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction in IDLE and returns during its EXEC cycle.
    task automatic applyStimulus(input logic [7:0] code);
        instrValid = 1'b1;
        instr      = code;
        checkOutput("ready_before_accept", instrReady, 1'b1);
        nextCycle();
        instrValid = 1'b0;
    endtask

    initial begin
        logic [7:0] badOps [4];
        badOps = '{8'hF3, 8'h23, 8'h3C, 8'h81};

        rstN       = 1'b0;
        instrValid = 1'b0;
        instr      = 8'h00;
        aluDone    = 1'b0;
        #1;
        checkOutput("rst_ready", instrReady, 1'b1);
        checkOutput("rst_count", retiredCount, 16'h0000);
        checkOutput("rst_op", aluOpSelect, 3'b000);
        checkOutput("rst_index", outIndex, 5'h00);
        checkOutput("rst_timeout", timeoutErr, 1'b0);

        instrValid = 1'b1;
        instr      = 8'h03;
        nextCycle();
        nextCycle();
        checkOutput("rst_handshake_ignored_ready", instrReady, 1'b1);
        checkOutput("rst_handshake_ignored_retire", retire, 1'b0);
        instrValid = 1'b0;
        rstN       = 1'b1;
        nextCycle();

        // ADD 0x03
        applyStimulus(8'h03);
        checkOutput("add_op", aluOpSelect, 3'b000);
        checkOutput("add_sub", aluSub, 1'b0);
        checkOutput("add_retire", retire, 1'b1);
        checkOutput("add_ready_exec", instrReady, 1'b0);
        nextCycle();
        expCount++;
        checkOutput("add_ready_after", instrReady, 1'b1);
        checkOutput("add_count", retiredCount, expCount);
        checkOutput("add_retire_after", retire, 1'b0);

        // SUB 0x15
        applyStimulus(8'h15);
        checkOutput("sub_op", aluOpSelect, 3'b001);
        checkOutput("sub_sub", aluSub, 1'b1);
        checkOutput("sub_retire", retire, 1'b1);
        nextCycle();
        expCount++;
        checkOutput("sub_count", retiredCount, expCount);

        // MUL 0x42, done during EXEC ignored, real done 5 cycles after start
        applyStimulus(8'h42);
        aluDone = 1'b1;
        #1;
        checkOutput("mul_start", aluStart, 1'b1);
        checkOutput("mul_op_exec", aluOpSelect, 3'b100);
        checkOutput("mul_retire_exec", retire, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            nextCycle();
            aluDone = 1'b0;
            #1;
            checkOutput("mul_start_wait", aluStart, 1'b0);
            checkOutput("mul_op_wait", aluOpSelect, 3'b100);
            checkOutput("mul_sub_wait", aluSub, 1'b0);
            checkOutput("mul_retire_wait", retire, 1'b0);
            checkOutput("mul_ready_wait", instrReady, 1'b0);
        end
        nextCycle();
        aluDone = 1'b1;
        #1;
        checkOutput("mul_retire_done", retire, 1'b1);
        checkOutput("mul_op_done", aluOpSelect, 3'b100);
        nextCycle();
        aluDone = 1'b0;
        expCount++;
        checkOutput("mul_ready_after", instrReady, 1'b1);
        checkOutput("mul_count", retiredCount, expCount);

        // OUT_W 0x6A then OUT_R 0x75
        applyStimulus(8'h6A);
        checkOutput("outw_we", outWe, 1'b1);
        checkOutput("outw_re", outRe, 1'b0);
        checkOutput("outw_index", outIndex, 5'h0A);
        checkOutput("outw_retire", retire, 1'b1);
        checkOutput("outw_op", aluOpSelect, 3'b000);
        nextCycle();
        expCount++;
        checkOutput("outw_we_after", outWe, 1'b0);
        checkOutput("outw_count", retiredCount, expCount);
        applyStimulus(8'h75);
        checkOutput("outr_re", outRe, 1'b1);
        checkOutput("outr_we", outWe, 1'b0);
        checkOutput("outr_index", outIndex, 5'h05);
        checkOutput("outr_retire", retire, 1'b1);
        nextCycle();
        expCount++;
        checkOutput("outr_re_after", outRe, 1'b0);
        checkOutput("outr_count", retiredCount, expCount);

        // Undefined opcodes
        foreach (badOps[k]) begin
            applyStimulus(badOps[k]);
            checkOutput("ill_pulse", illegal, 1'b1);
            checkOutput("ill_retire", retire, 1'b0);
            checkOutput("ill_start", aluStart, 1'b0);
            nextCycle();
            checkOutput("ill_pulse_after", illegal, 1'b0);
            checkOutput("ill_ready", instrReady, 1'b1);
            checkOutput("ill_count", retiredCount, expCount);
        end

`ifdef ALU_SEQ_TIMEOUT_EN
        // DIV without done: abort after 8 WAIT cycles
        applyStimulus(8'h51);
        checkOutput("to_start", aluStart, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            nextCycle();
            checkOutput("to_ready_wait", instrReady, 1'b0);
            checkOutput("to_err_wait", timeoutErr, 1'b0);
            checkOutput("to_op_wait", aluOpSelect, 3'b101);
        end
        nextCycle();
        checkOutput("to_ready_after", instrReady, 1'b1);
        checkOutput("to_err_set", timeoutErr, 1'b1);
        checkOutput("to_count", retiredCount, expCount);
        applyStimulus(8'h02);
        checkOutput("to_next_retire", retire, 1'b1);
        nextCycle();
        expCount++;
        checkOutput("to_err_sticky", timeoutErr, 1'b1);
        checkOutput("to_next_count", retiredCount, expCount);
`else
        // DIV waits indefinitely without the abort counter
        applyStimulus(8'h51);
        checkOutput("nto_start", aluStart, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            nextCycle();
        end
        checkOutput("nto_ready_wait", instrReady, 1'b0);
        checkOutput("nto_err", timeoutErr, 1'b0);
        checkOutput("nto_op_wait", aluOpSelect, 3'b101);
        aluDone = 1'b1;
        #1;
        checkOutput("nto_retire", retire, 1'b1);
        nextCycle();
        aluDone = 1'b0;
        expCount++;
        checkOutput("nto_count", retiredCount, expCount);
        checkOutput("nto_ready_after", instrReady, 1'b1);
`endif

        // DIV 0x50 with asynchronous reset mid-WAIT
        applyStimulus(8'h50);
        nextCycle();
        nextCycle();
        checkOutput("div_ready_wait", instrReady, 1'b0);
        checkOutput("div_op_wait", aluOpSelect, 3'b101);
        #2;
        rstN = 1'b0;
        #1;
        expCount = 0;
        checkOutput("arst_ready", instrReady, 1'b1);
        checkOutput("arst_op", aluOpSelect, 3'b000);
        checkOutput("arst_start", aluStart, 1'b0);
        checkOutput("arst_count", retiredCount, expCount);
        checkOutput("arst_index", outIndex, 5'h00);
        checkOutput("arst_timeout", timeoutErr, 1'b0);
        nextCycle();
        rstN = 1'b1;
        nextCycle();
        applyStimulus(8'h09);
        checkOutput("post_add_retire", retire, 1'b1);
        nextCycle();
        expCount++;
        checkOutput("post_add_count", retiredCount, expCount);
        checkOutput("post_add_ready", instrReady, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
